// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared FSM encoding, BCD constants and hour-limit helper for the countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    // True when the two-digit BCD hour value does not exceed hour_max.
    function automatic logic hour_ok(input logic [3:0] tens, input logic [3:0] units, input int hour_max);
        return ((int'(tens) * 10) + int'(units)) <= hour_max;
    endfunction

endpackage

// File: rtl/bcd_down_pair.sv
// rtl/bcd_down_pair.sv - modulo-N two-digit BCD down counter with load, decrement enable and borrow out
module bcd_down_pair
    import timer_pkg::*;
#(
    parameter int N = 60
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] load_tens_i,
    input  logic [3:0] load_units_i,
    input  logic       dec_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       zero_o,
    output logic       borrow_o
);

    localparam logic [3:0] TOP_TENS  = 4'((N - 1) / 10);
    localparam logic [3:0] TOP_UNITS = 4'((N - 1) % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    assign zero_o   = (tens_q == 4'd0) && (units_q == 4'd0);
    assign borrow_o = dec_i && zero_o;
    assign tens_o   = tens_q;
    assign units_o  = units_q;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (load_i) begin
            tens_d  = load_tens_i;
            units_d = load_units_i;
        end else if (dec_i) begin
            // Wrapping from 00 to N-1 is what lets the next pair up see the borrow.
            if (zero_o) begin
                tens_d  = TOP_TENS;
                units_d = TOP_UNITS;
            end else if (units_q == 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = BCD_NINE;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/countdown_timer_hms.sv
// rtl/countdown_timer_hms.sv - BCD HH:MM:SS countdown timer; AUTO_RELOAD_EN reloads the preset on expiry
module countdown_timer_hms
    import timer_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [3:0] set_hour1_i,
    input  logic [3:0] set_hour0_i,
    input  logic [3:0] set_min1_i,
    input  logic [3:0] set_min0_i,
    input  logic [3:0] set_sec1_i,
    input  logic [3:0] set_sec0_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       ack_i,
    output logic [3:0] hour1_o,
    output logic [3:0] hour0_o,
    output logic [3:0] min1_o,
    output logic [3:0] min0_o,
    output logic [3:0] sec1_o,
    output logic [3:0] sec0_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       done_o,
    output logic       load_err_o
);

    state_e      state_q, state_d;
    logic [23:0] preset_q, preset_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;

    logic        load_valid, load_active, do_load, reload, pair_load;
    logic        dec, expiring, count_zero, count_one;
    logic        sec_zero, min_zero, hour_zero, sec_borrow, min_borrow, hour_borrow;
    logic [23:0] set_bcd, load_bcd;

    assign set_bcd = {set_hour1_i, set_hour0_i, set_min1_i, set_min0_i, set_sec1_i, set_sec0_i};

    assign load_valid = (set_hour1_i <= BCD_NINE) && (set_hour0_i <= BCD_NINE) &&
                        (set_min1_i <= BCD_FIVE) && (set_min0_i <= BCD_NINE) &&
                        (set_sec1_i <= BCD_FIVE) && (set_sec0_i <= BCD_NINE) &&
                        hour_ok(set_hour1_i, set_hour0_i, HOUR_MAX);

    // A load in RUN is ignored entirely, so it never masks stop or tick there.
    assign load_active = load_i && (state_q != ST_RUN);
    assign do_load     = load_active && load_valid;
    assign dec         = (state_q == ST_RUN) && tick_i && !stop_i;
    assign count_zero  = hour_zero && min_zero && sec_zero;
    assign count_one   = hour_zero && min_zero && (sec1_o == 4'd0) && (sec0_o == 4'd1);
    assign expiring    = dec && count_one;

`ifdef AUTO_RELOAD_EN
    assign reload = expiring;
`else
    assign reload = 1'b0;
`endif

    assign pair_load = do_load || reload;
    assign load_bcd  = do_load ? set_bcd : preset_q;
    assign preset_d  = do_load ? set_bcd : preset_q;
    assign done_d    = expiring;
    assign load_err_d = load_active && !load_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (!load_i && !stop_i && start_i && !count_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_PAUSE;
                end else if (expiring && !reload) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (load_i) begin
                    if (load_valid) begin
                        state_d = ST_IDLE;
                    end
                end else if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            preset_q   <= 24'd0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_down_pair #(.N(60)) u_sec (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(pair_load),
        .load_tens_i(load_bcd[7:4]), .load_units_i(load_bcd[3:0]), .dec_i(dec),
        .tens_o(sec1_o), .units_o(sec0_o), .zero_o(sec_zero), .borrow_o(sec_borrow)
    );

    bcd_down_pair #(.N(60)) u_min (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(pair_load),
        .load_tens_i(load_bcd[15:12]), .load_units_i(load_bcd[11:8]), .dec_i(sec_borrow),
        .tens_o(min1_o), .units_o(min0_o), .zero_o(min_zero), .borrow_o(min_borrow)
    );

    bcd_down_pair #(.N(HOUR_MAX + 1)) u_hour (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(pair_load),
        .load_tens_i(load_bcd[23:20]), .load_units_i(load_bcd[19:16]), .dec_i(min_borrow),
        .tens_o(hour1_o), .units_o(hour0_o), .zero_o(hour_zero), .borrow_o(hour_borrow)
    );

    assign running_o  = (state_q == ST_RUN);
    assign expired_o  = (state_q == ST_EXPIRED);
    assign done_o     = done_q;
    assign load_err_o = load_err_q;

    // The hour pair never wraps because a running count is never zero.
    logic unused_ok;
    assign unused_ok = hour_borrow;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// tb/tb_countdown_timer_hms.sv - directed plus randomized bench with a seconds-based reference model
module tb_countdown_timer_hms;

    localparam int HMAX = 23;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0, tick_i = 1'b0, load_i = 1'b0;
    logic       start_i = 1'b0, stop_i = 1'b0, ack_i = 1'b0;
    logic [23:0] set_v = 24'd0;
    logic [3:0] hour1_o, hour0_o, min1_o, min0_o, sec1_o, sec0_o;
    logic       running_o, expired_o, done_o, load_err_o;

    int checks = 0;
    int errors = 0;

    // Model: count held as plain seconds; state 0 idle, 1 run, 2 pause, 3 expired.
    int m_cnt = 0, m_preset = 0, m_st = 0;
    bit m_done = 0, m_err = 0;

    countdown_timer_hms #(.HOUR_MAX(HMAX)) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .load_i(load_i),
        .set_hour1_i(set_v[23:20]), .set_hour0_i(set_v[19:16]),
        .set_min1_i(set_v[15:12]), .set_min0_i(set_v[11:8]),
        .set_sec1_i(set_v[7:4]), .set_sec0_i(set_v[3:0]),
        .start_i(start_i), .stop_i(stop_i), .ack_i(ack_i),
        .hour1_o(hour1_o), .hour0_o(hour0_o), .min1_o(min1_o), .min0_o(min0_o),
        .sec1_o(sec1_o), .sec0_o(sec0_o),
        .running_o(running_o), .expired_o(expired_o), .done_o(done_o), .load_err_o(load_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] dut_digits();
        return {hour1_o, hour0_o, min1_o, min0_o, sec1_o, sec0_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int h1, h0, m1, m0, s1, s0;
        bit valid;
        h1 = int'(set_v[23:20]); h0 = int'(set_v[19:16]);
        m1 = int'(set_v[15:12]); m0 = int'(set_v[11:8]);
        s1 = int'(set_v[7:4]);   s0 = int'(set_v[3:0]);
        valid = (h1 <= 9) && (h0 <= 9) && (m1 <= 5) && (m0 <= 9) && (s1 <= 5) && (s0 <= 9) &&
                (h1 * 10 + h0 <= HMAX);
        m_done = 0;
        m_err  = 0;
        if (reset_i) begin
            m_cnt = 0; m_preset = 0; m_st = 0;
        end else if (load_i && m_st != 1) begin
            if (valid) begin
                m_cnt = (h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60 + s1 * 10 + s0;
                m_preset = m_cnt;
                if (m_st == 3) m_st = 0;
            end else begin
                m_err = 1;
            end
        end else if (m_st == 1) begin
            if (stop_i) m_st = 2;
            else if (tick_i) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1;
`ifdef AUTO_RELOAD_EN
                    m_cnt = m_preset;
`else
                    m_st = 3;
`endif
                end
            end
        end else if (m_st == 0 || m_st == 2) begin
            if (!stop_i && start_i && m_cnt != 0) m_st = 1;
        end else if (m_st == 3) begin
            if (ack_i) m_st = 0;
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs are compared 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("digits", 32'(dut_digits()), 32'(to_bcd(m_cnt)));
        check("running", 32'(running_o), 32'(m_st == 1));
        check("expired", 32'(expired_o), 32'(m_st == 3));
        check("done", 32'(done_o), 32'(m_done));
        check("load_err", 32'(load_err_o), 32'(m_err));
        reset_i = 0; tick_i = 0; load_i = 0; start_i = 0; stop_i = 0; ack_i = 0;
    endtask

    task automatic do_load(input logic [23:0] v);
        set_v = v;
        load_i = 1;
        step();
    endtask

    task automatic do_tick();
        tick_i = 1;
        step();
    endtask

    int done_seen;

    initial begin
        #1;
        reset_i = 1;
        step();
        check("reset_digits", 32'(dut_digits()), 32'h0);
        check("reset_flags", 32'({running_o, expired_o, done_o, load_err_o}), 32'h0);

        // 1: 00:01:05 counted down with 65 ticks, then one extra tick.
        do_load(24'h000105);
        start_i = 1; step();
        done_seen = 0;
        for (int i = 0; i < 65; i++) begin
            do_tick();
            done_seen += int'(done_o);
        end
        check("t1_done_once", 32'(done_seen), 32'd1);
`ifndef AUTO_RELOAD_EN
        check("t1_zero", 32'(dut_digits()), 32'h0);
        check("t1_expired", 32'(expired_o), 32'd1);
        do_tick();
        check("t1_hold", 32'(dut_digits()), 32'h0);
        ack_i = 1; step();
`else
        stop_i = 1; step();
`endif

        // 2: hour borrow.
        do_load(24'h010000);
        start_i = 1; step();
        do_tick();
        check("t2_digits", 32'(dut_digits()), 32'h005959);
        check("t2_running", 32'(running_o), 32'd1);
        stop_i = 1; step();

        // 3: rejected loads leave the count untouched.
        do_load(24'h000060);
        check("t3_err_sec", 32'(load_err_o), 32'd1);
        check("t3_digits", 32'(dut_digits()), 32'h005959);
        do_load(24'h240000);
        check("t3_err_hour", 32'(load_err_o), 32'd1);
        step();
        check("t3_err_clear", 32'(load_err_o), 32'd0);

        // 4: stop beats a same-cycle tick.
        do_load(24'h001000);
        start_i = 1; step();
        stop_i = 1; tick_i = 1; step();
        check("t4_hold", 32'(dut_digits()), 32'h001000);
        check("t4_paused", 32'(running_o), 32'd0);
        start_i = 1; step();
        do_tick();
        check("t4_dec", 32'(dut_digits()), 32'h000959);

        // 5: reset while running.
        stop_i = 1; step();
        do_load(24'h003012);
        start_i = 1; step();
        reset_i = 1; step();
        check("t5_digits", 32'(dut_digits()), 32'h0);
        check("t5_running", 32'(running_o), 32'd0);
        do_tick();
        check("t5_tick", 32'(dut_digits()), 32'h0);

`ifdef AUTO_RELOAD_EN
        // 6: expiry reloads the preset and keeps running.
        do_load(24'h000003);
        start_i = 1; step();
        do_tick(); do_tick(); do_tick();
        check("t6_done", 32'(done_o), 32'd1);
        check("t6_digits", 32'(dut_digits()), 32'h000003);
        check("t6_flags", 32'({running_o, expired_o}), 32'b10);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            load_i  = ($urandom_range(0, 19) == 0);
            set_v   = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 10)),
                       4'($urandom_range(0, 6)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            if ($urandom_range(0, 3) != 0) set_v[23:8] = 16'h0000;
            start_i = ($urandom_range(0, 7) == 0);
            stop_i  = ($urandom_range(0, 31) == 0);
            tick_i  = ($urandom_range(0, 1) == 0);
            ack_i   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
